calc_cmd_sequencer: RTL

//  Initiator for the FSM calculator's serial command protocol. Accepts operations {a,b,opcode}
//  on a valid/ready port into a small FIFO, serialises each onto iniciar/dados, waits for

---
 rtl/calc_cmd_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/calc_cmd_sequencer.sv
// Command sequencer for the FSM calculator: queues {a,b,op} operations, serialises each
// onto iniciar/dados, waits for pronto (or a timeout) and returns the result on a response port.
module calc_cmd_sequencer #(
  parameter int WORD_WIDTH     = 8,
  parameter int RESULT_WIDTH   = 16,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              cmd_a,
  input  logic [3:0]              cmd_b,
  input  logic [2:0]              cmd_op,
  output logic                    iniciar,
  output logic [WORD_WIDTH-1:0]   dados,
  input  logic                    pronto,
  input  logic [RESULT_WIDTH-1:0] result_in,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [RESULT_WIDTH-1:0] rsp_result,
  output logic                    rsp_timeout,
  output logic                    busy
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CMD_W = 11;

  typedef enum logic [2:0] {
    IDLE, START, SEND_A, SEND_B, SEND_OP, WAIT_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CMD_W-1:0]        fifo_mem [CMD_DEPTH];
  logic [PTR_W:0]          wr_ptr_q, rd_ptr_q;
  logic [CMD_W-1:0]        cur_cmd_q, cur_cmd_d;
  logic [CNT_W-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic [RESULT_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic                    fifo_empty, fifo_full, push, pop;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {cmd_a, cmd_b, cmd_op};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cur_cmd_q     <= '0;
      tmo_cnt_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_result_q  <= '0;
    end else begin
      state_q       <= state_d;
      cur_cmd_q     <= cur_cmd_d;
      tmo_cnt_q     <= tmo_cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_result_q  <= rsp_result_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cur_cmd_d     = cur_cmd_q;
    tmo_cnt_d     = tmo_cnt_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_result_d  = rsp_result_q;
    pop           = 1'b0;
    iniciar       = 1'b0;
    dados         = '0;

    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Launch only when the response slot is free or being freed this cycle.
        if (!fifo_empty && (!rsp_valid_q || rsp_ready)) begin
          pop       = 1'b1;
          cur_cmd_d = fifo_mem[rd_ptr_q[PTR_W-1:0]];
          state_d   = START;
        end
      end
      START: begin
        iniciar = 1'b1;
        state_d = SEND_A;
      end
      SEND_A: begin
        dados   = WORD_WIDTH'(cur_cmd_q[10:7]);
        state_d = SEND_B;
      end
      SEND_B: begin
        dados   = WORD_WIDTH'(cur_cmd_q[6:3]);
        state_d = SEND_OP;
      end
      SEND_OP: begin
        dados     = WORD_WIDTH'(cur_cmd_q[2:0]);
        tmo_cnt_d = '0;
        state_d   = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (pronto) begin
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b0;
          rsp_result_d  = result_in;
          state_d       = IDLE;
        end else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_result_d  = '0;
          state_d       = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_result  = rsp_result_q;
  assign busy        = (state_q != IDLE) || !fifo_empty;

endmodule
